fifo_stream_reader: RTL and testbench

Downstream drain stage for the FIFO block. Watches the FIFO `empty` flag, issues single-cycle `read` pulses, absorbs the one-cycle registered RAM read latency, and presents the words as a valid/ready stream to the consumer. A 2-entry skid buffer keeps consumer back-pressure from dropping or duplicating words, and sustains one word per cycle when the consumer is always ready.

---
 rtl/fifo_stream_reader.sv | 105 ++++++++++
 tb/tb_fifo_stream_reader.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - FIFO drain stage with 2-entry skid buffer and valid/ready output
//
// Purpose: watches the FIFO empty flag, issues single-cycle read strobes, absorbs
// the one-cycle registered RAM read latency and presents words as a valid/ready
// stream. Buffered plus in-flight words never exceed 2, so back-pressure never
// drops or duplicates a word; one word per cycle is sustained when always ready.
//
// Optional feature: define READER_COUNT_EN to add the o_out_count port and its
// wrapping 16-bit delivered-word counter.
//
// Ports:
//   i_clk          clock, rising edge
//   i_reset        asynchronous active-low reset
//   i_fifo_empty   FIFO empty flag
//   i_fifo_data    FIFO read data, valid the cycle after o_fifo_read
//   o_fifo_read    FIFO pop strobe
//   o_out_data     word at the head of the skid buffer
//   o_out_valid    o_out_data holds a word
//   i_out_ready    consumer accepts o_out_data this cycle
//   o_out_count    words delivered, wrapping (READER_COUNT_EN only)

module fifo_stream_reader #(
  parameter int width = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_fifo_empty,
  input  logic [width-1:0] i_fifo_data,
  output logic             o_fifo_read,
  output logic [width-1:0] o_out_data,
  output logic             o_out_valid,
  input  logic             i_out_ready
`ifdef READER_COUNT_EN
  ,
  output logic [15:0]      o_out_count
`endif
);

  logic [1:0]       r_occ;
  logic             r_inflight;
  logic [width-1:0] r_head;
  logic [width-1:0] r_tail;

  logic             w_pop;
  logic [2:0]       w_level;
  logic             w_credit;
  logic [1:0]       w_occ_after_pop;

  assign w_pop = (r_occ != 2'd0) && i_out_ready;

  // Words that will be held after this edge if no new read is issued.
  // A pop implies r_occ >= 1, so the subtraction never underflows.
  assign w_level  = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_credit = (w_level < 3'd2);

  assign w_occ_after_pop = r_occ - {1'b0, w_pop};

  // Gated by the reset input so the strobe is low while reset is held.
  assign o_fifo_read = i_reset && !i_fifo_empty && w_credit;

  assign o_out_valid = (r_occ != 2'd0);
  assign o_out_data  = r_head;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_occ      <= 2'd0;
      r_inflight <= 1'b0;
      r_head     <= '0;
      r_tail     <= '0;
    end else begin
      r_inflight <= o_fifo_read;
      r_occ      <= w_occ_after_pop + {1'b0, r_inflight};

      // Retire head; the tail word (if any) moves up on the same edge.
      if (w_pop && (r_occ == 2'd2)) begin
        r_head <= r_tail;
      end

      // Arriving word lands in the first free slot after the pop. The credit
      // rule guarantees at most one word is buffered when data arrives.
      if (r_inflight) begin
        if (w_occ_after_pop == 2'd0) begin
          r_head <= i_fifo_data;
        end else begin
          r_tail <= i_fifo_data;
        end
      end
    end
  end

`ifdef READER_COUNT_EN
  logic [15:0] r_count;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_count <= 16'h0000;
    end else if (w_pop) begin
      r_count <= r_count + 16'h0001;
    end
  end

  assign o_out_count = r_count;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb/tb_fifo_stream_reader.sv - directed self-checking bench for fifo_stream_reader

module tb_fifo_stream_reader;

  logic       clk;
  logic       rst_n;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_read;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
`ifdef READER_COUNT_EN
  logic [15:0] out_count;
`endif

  fifo_stream_reader #(.width(8)) dut (
    .i_clk        (clk),
    .i_reset      (rst_n),
    .i_fifo_empty (fifo_empty),
    .i_fifo_data  (fifo_data),
    .o_fifo_read  (fifo_read),
    .o_out_data   (out_data),
    .o_out_valid  (out_valid),
    .i_out_ready  (out_ready)
`ifdef READER_COUNT_EN
    ,
    .o_out_count  (out_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO model: registered read data, empty updates on the popping edge,
  // flushed by the shared reset.
  logic [7:0] mem [0:127];
  int         wr_ptr;
  int         rd_ptr;
  int         n_reads;
  int         n_overreads;

  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr    <= wr_ptr;
      fifo_data <= 8'h00;
    end else if (fifo_read) begin
      if (wr_ptr == rd_ptr) begin
        n_overreads <= n_overreads + 1;
      end else begin
        fifo_data <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + 1;
      end
      n_reads <= n_reads + 1;
    end
  end

  int n_checks;
  int n_pass;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push(input logic [7:0] v);
    mem[wr_ptr] = v;
    wr_ptr      = wr_ptr + 1;
  endtask

  logic [7:0] got_words [0:31];
  int         got_n;
  int         first_k;
  int         last_k;
  int         reads0;

  initial begin
    wr_ptr      = 0;
    n_reads     = 0;
    n_overreads = 0;
    n_checks    = 0;
    n_pass      = 0;
    out_ready   = 1'b0;
    rst_n       = 1'b0;

    // Reset and idle
    for (int k = 0; k < 2; k++) begin
      tick();
      check("rst_read", {31'd0, fifo_read}, 32'd0);
      check("rst_valid", {31'd0, out_valid}, 32'd0);
      check("rst_data", {24'd0, out_data}, 32'd0);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    check("idle_valid", {31'd0, out_valid}, 32'd0);
    check("idle_reads", n_reads, 32'd0);

    // Single word, two-cycle latency, one-cycle valid
    out_ready = 1'b1;
    reads0 = n_reads;
    push(8'h01);
    #1;
    check("single_read_comb", {31'd0, fifo_read}, 32'd1);
    tick();
    check("single_k1_valid", {31'd0, out_valid}, 32'd0);
    tick();
    check("single_k2_valid", {31'd0, out_valid}, 32'd1);
    check("single_k2_data", {24'd0, out_data}, 32'h01);
    tick();
    check("single_k3_valid", {31'd0, out_valid}, 32'd0);
    tick();
    check("single_reads", n_reads - reads0, 32'd1);

    // Streaming 15 words with ready held high
    reads0 = n_reads;
    for (int i = 1; i <= 15; i++) push(i[7:0]);
    got_n = 0; first_k = -1; last_k = -1;
    for (int k = 0; k <= 20; k++) begin
      if (out_valid) begin
        if (got_n < 32) got_words[got_n] = out_data;
        got_n++;
        if (first_k < 0) first_k = k;
        last_k = k;
      end
      tick();
    end
    check("stream_count", got_n, 32'd15);
    check("stream_first_k", first_k, 32'd2);
    check("stream_last_k", last_k, 32'd16);
    for (int i = 0; i < 15; i++) check("stream_word", {24'd0, got_words[i]}, i + 1);
    check("stream_reads", n_reads - reads0, 32'd15);

    // Back-pressure: ready low for 10 cycles
    out_ready = 1'b0;
    reads0 = n_reads;
    for (int i = 0; i < 5; i++) push(8'h21 + i[7:0]);
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k >= 2) check("bp_hold", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h21});
    end
    check("bp_reads", n_reads - reads0, 32'd2);
    out_ready = 1'b1;
    got_n = 0;
    for (int k = 0; k < 12; k++) begin
      if (out_valid) begin
        if (got_n < 32) got_words[got_n] = out_data;
        got_n++;
      end
      tick();
    end
    check("bp_count", got_n, 32'd5);
    for (int i = 0; i < 5; i++) check("bp_word", {24'd0, got_words[i]}, 32'h21 + i);

    // Reset mid-stream with inflight=1, occ=1
    out_ready = 1'b0;
    push(8'h31);
    push(8'h32);
    push(8'h33);
    tick();
    tick();
    check("mid_pre_valid", {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_async_valid", {31'd0, out_valid}, 32'd0);
    check("mid_async_data", {24'd0, out_data}, 32'd0);
    check("mid_async_read", {31'd0, fifo_read}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    reads0 = n_reads;
    for (int k = 0; k < 3; k++) tick();
    check("mid_post_valid", {31'd0, out_valid}, 32'd0);
    check("mid_post_reads", n_reads - reads0, 32'd0);
    out_ready = 1'b1;
    push(8'h42);
    tick();
    check("resume_k1_valid", {31'd0, out_valid}, 32'd0);
    tick();
    check("resume_k2", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h42});
    tick();
    check("resume_k3_valid", {31'd0, out_valid}, 32'd0);

`ifdef READER_COUNT_EN
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("cnt_reset", {16'd0, out_count}, 32'd0);
    push(8'h51);
    push(8'h52);
    push(8'h53);
    for (int k = 0; k < 6; k++) tick();
    check("cnt_three", {16'd0, out_count}, 32'd3);
    force dut.r_count = 16'hFFFF;
    #1;
    release dut.r_count;
    push(8'h54);
    for (int k = 0; k < 4; k++) tick();
    check("cnt_wrap", {16'd0, out_count}, 32'd0);
`endif

    check("no_overread", n_overreads, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
